inst_fetch: RTL and testbench
=============================

// Module: inst_fetch
// PURPOSE
//  Read-side master for instmem. Drives addIM, captures outIM, tags each word with its PC.
//  Buffers words in a small prefetch queue.
//  Hands them to decode over a valid/ready handshake.
//  Supports redirect (branch/jump) with flush, and a halt input that stops new fetches.
// PARAMETERS
//  ADDR_W     12      instruction address width (matches addIM)
//  INSTR_W    16      instruction width (matches outIM)
//  FQ_DEPTH   2       prefetch queue entries; power of 2, >=2
//  RESET_PC   12'h000 PC loaded on reset
// PORTS
//  clk          in   1        system clock, rising edge
//  rst_n        in   1        synchronous reset, active low
//  addIM        out  ADDR_W   read address to instmem
//  outIM        in   INSTR_W  instmem read data, valid 1 cycle after addIM sampled
//  halt         in   1        1 = issue no new fetches; queue still drains
//  branch_en    in   1        redirect strobe, 1 cycle
//  branch_addr  in   ADDR_W   redirect target
//  ir_valid     out  1        ir_data/ir_pc hold a valid instruction
//  ir_ready     in   1        decode accepts when ir_valid & ir_ready
//  ir_data      out  INSTR_W  instruction word
//  ir_pc        out  ADDR_W   address the word was fetched from
// BEHAVIOUR
//  - Reset: pc=RESET_PC, addIM=RESET_PC, req_vld=0, queue empty, ir_valid=0, ir_data=0, ir_pc=0.
//  - addIM = pc register.
//  - Issue cycle: !halt & !branch_en & (occupancy+req_vld) < FQ_DEPTH.
//    On issue: req_vld<=1, req_pc<=pc, pc<=pc+1; otherwise req_vld<=0.
//  - Return: when req_vld=1, push {req_pc,outIM} into queue at the end of that cycle.
//    The credit rule guarantees no overflow.
//  - Latency: first ir_valid 2 cycles after rst_n rises; thereafter 1 instr/cycle while ir_ready=1.
//  - Handshake: pop on ir_valid&ir_ready. ir_data/ir_pc hold stable while ir_valid&!ir_ready.
//    Push and pop in the same cycle are legal at any occupancy.
//  - Redirect: branch_en=1 -> pc<=branch_addr, queue cleared, req_vld<=0.
//    The returning outIM that cycle is discarded and no issue occurs.
//    ir_valid=0 next cycle; first redirected word is visible 2 cycles after branch_en.
//  - branch_en and halt together: redirect applies, then fetch stays halted.
//  - Wrap: pc 12'hFFF + 1 = 12'h000, no flag.
//  - Reset mid-operation: all state returns to reset values at the next edge; in-flight data dropped.
// CONFIGURATION
//  FETCH_PERF_EN defined: adds outputs perf_fetch[15:0] and perf_stall[15:0].
//   - perf_fetch: pops.
//   - perf_stall: cycles ir_valid&!ir_ready.
//   - Both saturate at 16'hFFFF and clear on reset.
//  FETCH_PERF_EN undefined: ports and counters absent; all other behaviour identical.
// STRUCTURE
//  cpu_pkg: ADDR_W, INSTR_W, RESET_PC constants; fetch_entry_t typedef {pc, instr}.
//  Sub-module fetch_fifo:
//   - Synchronous FIFO of fetch_entry_t, FQ_DEPTH deep.
//   - Ports: push, pop, clear, count, head.
//   - Sync clear on rst_n=0 or clear.
//  Top holds pc, req_vld/req_pc and credit logic.
// TESTING
//  T1 instmem[0..3]=0234,0381,1111,2222; ir_ready=1; release reset.
//     -> ir_valid at cycle 2 with pc 000/0234, then 001/0381, 002/1111, 003/2222 on consecutive cycles.
//  T2 ir_ready=0 for 6 cycles after first valid.
//     -> ir holds 000/0234; addIM stops advancing after queue+in-flight=FQ_DEPTH.
//     -> on release, sequence continues with no loss or duplicate.
//  T3 queue full, branch_en with branch_addr=12'h100.
//     -> ir_valid=0 next cycle; next accepted word has pc 100; no pre-branch pc appears.
//  T4 branch to 12'hFFE, ir_ready=1.
//     -> ir_pc sequence FFE, FFF, 000, 001.
//  T5 halt=1 mid-stream.
//     -> addIM frozen; remaining queued words drain; ir_valid falls.
//     -> halt=0 resumes at the frozen addIM.
//  T6 rst_n=0 for 1 cycle mid-stream.
//     -> next cycle ir_valid=0, addIM=000; stream restarts from pc 000.
//     -> with FETCH_PERF_EN, counters read 0.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared CPU constants and the fetch queue entry type.
// Used by inst_fetch and fetch_fifo.
package cpu_pkg;
    localparam int              ADDR_W   = 12;
    localparam int              INSTR_W  = 16;
    localparam logic [ADDR_W-1:0] RESET_PC = 12'h000;

    typedef struct packed {
        logic [ADDR_W-1:0]  pc;
        logic [INSTR_W-1:0] instr;
    } fetch_entry_t;
endpackage

// File: rtl/fetch_fifo.sv
// Prefetch queue of PC-tagged instruction words.
// Clear, or rst_n low, empties it at the next edge.
module fetch_fifo
    import cpu_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int CW    = $clog2(DEPTH) + 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  logic         pop,
    input  logic         clear,
    input  fetch_entry_t din,
    output logic [CW-1:0] count,
    output fetch_entry_t head
);
    localparam int PW = CW - 1;

    fetch_entry_t    mem [DEPTH];
    logic [CW-1:0]   wr_ptr, rd_ptr;

    // Pointers carry one extra wrap bit so full and empty are distinct.
    assign count = wr_ptr - rd_ptr;
    assign head  = mem[rd_ptr[PW-1:0]];

    always_ff @(posedge clk) begin
        if (!rst_n || clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr[PW-1:0]] <= din;
    end
endmodule

// File: rtl/inst_fetch.sv
// Instruction fetch: drives instmem, queues PC-tagged words, hands them to decode.
// Optional perf counters enabled by defining FETCH_PERF_EN.
module inst_fetch
    import cpu_pkg::*;
#(
    parameter int                FQ_DEPTH = 2,
    parameter logic [ADDR_W-1:0] RST_PC   = RESET_PC
) (
    input  logic               clk,
    input  logic               rst_n,
    output logic [ADDR_W-1:0]  addIM,
    input  logic [INSTR_W-1:0] outIM,
    input  logic               halt,
    input  logic               branch_en,
    input  logic [ADDR_W-1:0]  branch_addr,
    output logic               ir_valid,
    input  logic               ir_ready,
    output logic [INSTR_W-1:0] ir_data,
    output logic [ADDR_W-1:0]  ir_pc
`ifdef FETCH_PERF_EN
    ,
    output logic [15:0]        perf_fetch,
    output logic [15:0]        perf_stall
`endif
);
    localparam int CW = $clog2(FQ_DEPTH) + 1;

    logic [ADDR_W-1:0] pc, req_pc;
    logic              req_vld;
    logic [CW-1:0]     count, occ;
    logic              fire, issue, push;
    fetch_entry_t      head, din;

    assign addIM    = pc;
    assign ir_valid = (count != '0);
    assign fire     = ir_valid & ir_ready;
    assign ir_data  = ir_valid ? head.instr : '0;
    assign ir_pc    = ir_valid ? head.pc    : '0;

    // A slot freed by this cycle's pop counts as available, which keeps
    // a two-entry queue streaming one word per cycle without overflow.
    assign occ   = count - CW'(fire) + CW'(req_vld);
    assign issue = !halt && !branch_en && (occ < CW'(FQ_DEPTH));
    assign push  = req_vld && !branch_en;
    assign din   = '{pc: req_pc, instr: outIM};

    fetch_fifo #(.DEPTH(FQ_DEPTH), .CW(CW)) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .pop   (fire),
        .clear (branch_en),
        .din   (din),
        .count (count),
        .head  (head)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pc      <= RST_PC;
            req_pc  <= '0;
            req_vld <= 1'b0;
        end else if (branch_en) begin
            pc      <= branch_addr;
            req_vld <= 1'b0;
        end else begin
            req_vld <= issue;
            if (issue) begin
                req_pc <= pc;
                pc     <= pc + 1'b1;
            end
        end
    end

`ifdef FETCH_PERF_EN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            perf_fetch <= '0;
            perf_stall <= '0;
        end else begin
            if (fire && perf_fetch != 16'hFFFF)
                perf_fetch <= perf_fetch + 1'b1;
            if (ir_valid && !ir_ready && perf_stall != 16'hFFFF)
                perf_stall <= perf_stall + 1'b1;
        end
    end
`endif
endmodule

// File: tb/tb_inst_fetch.sv
// Self-checking bench for inst_fetch: directed scenarios plus a random phase,
// checked against a stream model (expected next PC, mem lookup, hold-while-stalled).
module tb_inst_fetch;
    import cpu_pkg::*;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic [ADDR_W-1:0]  addIM;
    logic [INSTR_W-1:0] outIM;
    logic               halt = 1'b0;
    logic               branch_en = 1'b0;
    logic [ADDR_W-1:0]  branch_addr = '0;
    logic               ir_valid;
    logic               ir_ready = 1'b1;
    logic [INSTR_W-1:0] ir_data;
    logic [ADDR_W-1:0]  ir_pc;
`ifdef FETCH_PERF_EN
    logic [15:0]        perf_fetch, perf_stall;
`endif

    int nchk = 0;
    int nfail = 0;

    logic [INSTR_W-1:0] mem [4096];

    inst_fetch dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .addIM       (addIM),
        .outIM       (outIM),
        .halt        (halt),
        .branch_en   (branch_en),
        .branch_addr (branch_addr),
        .ir_valid    (ir_valid),
        .ir_ready    (ir_ready),
        .ir_data     (ir_data),
        .ir_pc       (ir_pc)
`ifdef FETCH_PERF_EN
        ,
        .perf_fetch  (perf_fetch),
        .perf_stall  (perf_stall)
`endif
    );

    always #5 clk = ~clk;

    // instmem: one-cycle registered read
    always @(posedge clk) outIM <= mem[addIM];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nchk++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Stream model: every accepted word must be the next program-order PC
    // with its instmem contents; a stalled word must not change.
    logic [ADDR_W-1:0]  exp_pc = RESET_PC;
    logic               held = 1'b0;
    logic [ADDR_W-1:0]  held_pc;
    logic [INSTR_W-1:0] held_data;
    int                 pops = 0;
    int                 stalls = 0;

    always @(negedge clk) begin
        if (!rst_n) begin
            exp_pc = RESET_PC;
            held   = 1'b0;
            pops   = 0;
            stalls = 0;
        end else begin
            if (held) begin
                check("hold_valid", 32'(ir_valid), 32'd1);
                check("hold_pc",    32'(ir_pc),    32'(held_pc));
                check("hold_data",  32'(ir_data),  32'(held_data));
            end
            if (ir_valid && ir_ready) begin
                check("stream_pc",   32'(ir_pc),   32'(exp_pc));
                check("stream_data", 32'(ir_data), 32'(mem[exp_pc]));
                exp_pc = exp_pc + 1'b1;
                pops++;
            end
            if (ir_valid && !ir_ready) stalls++;
            held      = ir_valid && !ir_ready && !branch_en;
            held_pc   = ir_pc;
            held_data = ir_data;
            if (branch_en) exp_pc = branch_addr;
        end
    end

    initial begin
        logic [ADDR_W-1:0]  frozen;
        logic [ADDR_W-1:0]  stall_pc;
        for (int i = 0; i < 4096; i++) mem[i] = INSTR_W'($urandom);
        mem[0] = 16'h0234; mem[1] = 16'h0381; mem[2] = 16'h1111; mem[3] = 16'h2222;

        // Reset state
        step(3);
        check("rst_valid", 32'(ir_valid), 32'd0);
        check("rst_data",  32'(ir_data),  32'd0);
        check("rst_pc",    32'(ir_pc),    32'd0);
        check("rst_addIM", 32'(addIM),    32'(RESET_PC));

        // T1: first word two cycles after reset release, then one per cycle
        rst_n = 1'b1;
        step();
        check("t1_lat_valid", 32'(ir_valid), 32'd0);
        step();
        check("t1_first_valid", 32'(ir_valid), 32'd1);
        check("t1_first_pc",    32'(ir_pc),    32'h000);
        check("t1_first_data",  32'(ir_data),  32'h0234);
        for (int i = 1; i < 4; i++) begin
            step();
            check("t1_valid", 32'(ir_valid), 32'd1);
            check("t1_pc",    32'(ir_pc),    32'(i));
            check("t1_data",  32'(ir_data),  32'(mem[i]));
        end

        // T2: decode stalls; fetch must back off
        ir_ready = 1'b0;
        stall_pc = ir_pc;
        step(3);
        frozen = addIM;
        step(3);
        check("t2_hold_pc",  32'(ir_pc), 32'(stall_pc));
        check("t2_addIM_frozen", 32'(addIM), 32'(frozen));
        ir_ready = 1'b1;
        step(6);

        // T3: redirect with a full queue
        ir_ready = 1'b0;
        step(4);
        branch_en = 1'b1; branch_addr = 12'h100;
        step();
        branch_en = 1'b0;
        check("t3_flush_valid", 32'(ir_valid), 32'd0);
        step(2);
        check("t3_target_valid", 32'(ir_valid), 32'd1);
        check("t3_target_pc",    32'(ir_pc),    32'h100);
        ir_ready = 1'b1;
        step(4);

        // T4: redirect across the address wrap
        branch_en = 1'b1; branch_addr = 12'hFFE;
        step();
        branch_en = 1'b0;
        step(2);
        check("t4_pc0", 32'(ir_pc), 32'hFFE);
        step();
        check("t4_pc1", 32'(ir_pc), 32'hFFF);
        step();
        check("t4_pc2", 32'(ir_pc), 32'h000);
        step();
        check("t4_pc3", 32'(ir_pc), 32'h001);

        // T5: halt freezes addIM, queue drains, resume at frozen address
        halt   = 1'b1;
        frozen = addIM;
        step(4);
        check("t5_addIM_frozen", 32'(addIM),    32'(frozen));
        check("t5_drained",      32'(ir_valid), 32'd0);
        halt = 1'b0;
        step(2);
        check("t5_resume_valid", 32'(ir_valid), 32'd1);
        check("t5_resume_pc",    32'(ir_pc),    32'(frozen));

        // Random phase
        for (int i = 0; i < 600; i++) begin
            ir_ready    = ($urandom_range(0, 9) < 7);
            halt        = ($urandom_range(0, 9) == 0);
            branch_en   = ($urandom_range(0, 19) == 0);
            branch_addr = ADDR_W'($urandom_range(0, 4095));
            rst_n       = ($urandom_range(0, 99) != 0);
            step();
        end
        halt = 1'b0; branch_en = 1'b0; rst_n = 1'b1; ir_ready = 1'b1;
        step(5);
`ifdef FETCH_PERF_EN
        check("perf_fetch_run", 32'(perf_fetch), 32'(pops));
        check("perf_stall_run", 32'(perf_stall), 32'(stalls));
`endif

        // T6: one-cycle reset mid-stream
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        check("t6_valid", 32'(ir_valid), 32'd0);
        check("t6_addIM", 32'(addIM),    32'(RESET_PC));
`ifdef FETCH_PERF_EN
        check("t6_perf_fetch", 32'(perf_fetch), 32'd0);
        check("t6_perf_stall", 32'(perf_stall), 32'd0);
`endif
        step(2);
        check("t6_restart_valid", 32'(ir_valid), 32'd1);
        check("t6_restart_pc",    32'(ir_pc),    32'h000);
        check("t6_restart_data",  32'(ir_data),  32'h0234);
        step(3);

        $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
        $finish;
    end
endmodule
